fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_nextpc.sv | 34 +++
 rtl/mux2.sv | 13 +
 rtl/fetch_unit.sv | 118 +++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory and core-side signals of the fetch unit
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        advance;
    logic        pcsrc;
    logic        jump;
    logic [31:0] signimm;
    logic [31:0] pc;
    logic [31:0] pcplus4;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc, pcplus4,
        input  imem_ready, imem_rdata, advance, pcsrc, jump, signimm
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc, pcplus4,
        output imem_ready, imem_rdata, advance, pcsrc, jump, signimm
    );

endinterface

// File: rtl/fetch_nextpc.sv
// rtl/fetch_nextpc.sv - combinational next-PC selection (sequential, branch, jump)
module fetch_nextpc (
    input  logic [31:0] pcplus4,
    input  logic [25:0] jindex,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic [31:0] signimm,
    output logic [31:0] nextpc
);

    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] seq_or_branch;

    // Branch offset is in words; the add wraps modulo 2^32.
    assign branch_target = pcplus4 + (signimm << 2);
    assign jump_target   = {pcplus4[31:28], jindex, 2'b00};

    // Branch select first, then jump overrides it so jump wins when both are set.
    mux2 #(.WIDTH(32)) u_branch_mux (
        .d0 (pcplus4),
        .d1 (branch_target),
        .s  (pcsrc),
        .y  (seq_or_branch)
    );

    mux2 #(.WIDTH(32)) u_jump_mux (
        .d0 (seq_or_branch),
        .d1 (jump_target),
        .s  (jump),
        .y  (nextpc)
    );

endmodule

// File: rtl/mux2.sv
// rtl/mux2.sv - generic two-input multiplexer
module mux2 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - two-state instruction fetch unit; FETCH_PERF_CNT_EN adds fetch/stall counters
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter bit          HOLD_ON_STALL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    // Word alignment mask: low address bits are always zero.
    localparam logic [31:0] PC_MASK = ~(INSTR_BYTES - 32'd1);

    fetch_state_t state_q;
    fetch_state_t next_state;
    logic         req_en_q;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic [31:0]  pcplus4;
    logic [31:0]  nextpc;
    logic         imem_req;
    logic         instr_valid;
    logic         accept;
    logic         retire;
    logic         load_instr;

    assign pcplus4 = pc_q + INSTR_BYTES;

    fetch_nextpc u_nextpc (
        .pcplus4 (pcplus4),
        .jindex  (instr_q[25:0]),
        .pcsrc   (bus.pcsrc),
        .jump    (bus.jump),
        .signimm (bus.signimm),
        .nextpc  (nextpc)
    );

    // Next-state and handshake decode; responses are only taken while a request is out.
    always_comb begin
        next_state  = state_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        accept      = 1'b0;
        retire      = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = req_en_q;
                if (req_en_q && bus.imem_ready) begin
                    accept     = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (bus.advance) begin
                    retire     = 1'b1;
                    next_state = FETCH;
                end
            end
            default: next_state = FETCH;
        endcase
    end

    // With HOLD_ON_STALL=0 the register may track the bus during FETCH; it never moves in HOLD.
    assign load_instr = accept || (!HOLD_ON_STALL && state_q == FETCH);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= next_state;
    end

    // Keeps imem_req low until the first clock edge after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) req_en_q <= 1'b0;
        else       req_en_q <= 1'b1;
    end

    // Program counter, updated only when the held instruction retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       pc_q <= RESET_PC & PC_MASK;
        else if (retire) pc_q <= nextpc & PC_MASK;
    end

    // Held instruction register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           instr_q <= 32'h0000_0000;
        else if (load_instr) instr_q <= bus.imem_rdata;
    end

`ifdef FETCH_PERF_CNT_EN
    // Accepted responses and FETCH cycles left waiting on memory, both free-running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt <= 32'h0000_0000;
            stall_cnt <= 32'h0000_0000;
        end else begin
            if (accept)                      fetch_cnt <= fetch_cnt + 32'd1;
            if (imem_req && !bus.imem_ready) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

    assign bus.imem_req    = imem_req;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid;
    assign bus.pc          = pc_q;
    assign bus.pcplus4     = pcplus4;

endmodule
